plus3_serial_ctrl: RTL
======================

Name: plus3_serial_ctrl

Overview:
- Sequencing controller for a bit-serial plus-3 (excess-3) converter.
- Accepts a parallel word of NDIG BCD digits over a valid/ready handshake and streams it LSB-first through the serial converter core, one bit per CLK.
- Reassembles the serial sum bits into a parallel excess-3 word, flags per-digit overflow, and presents the result on an output valid/ready handshake.
- Sits between parallel producer/consumer logic and the serial converter. It owns digit alignment, so the core is always restarted on 4-bit boundaries.

Parameters:
- NDIG, 2, number of BCD digits per word (1..8).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST_N  in  1  synchronous reset, active-low; sampled on posedge CLK.
- IN_DATA  in  4*NDIG  BCD digits; digit 0 in [3:0].
- IN_VALID  in  1  producer has a word.
- IN_READY  out  1  controller can accept a word.
- OUT_DATA  out  4*NDIG  excess-3 result; digit i = (IN digit i + 3) mod 16.
- OUT_OVF  out  NDIG  per-digit overflow; bit i set when IN digit i + 3 > 15.
- OUT_V  out  1  OR of OUT_OVF.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer takes the result.
- SER_X  out  1  bit currently driven into the core (debug).
- SER_S  out  1  core sum output for that bit (debug).

Behaviour:
- Reset (RST_N=0 at posedge):
  - state=IDLE, bit counter=0, core carry=0.
  - OUT_DATA=0, OUT_OVF=0, OUT_V=0, OUT_VALID=0, IN_READY=1 from the following cycle.
  - Reset overrides any handshake in the same cycle.
  - Reset mid-SHIFT or mid-DONE discards the word. No OUT_VALID is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - IN_READY=1, OUT_VALID=0.
  - IN_VALID=1 at posedge: latch IN_DATA into the shift register, clear the result register, clear OUT_OVF, counter=0, go to SHIFT.
- SHIFT:
  - IN_READY=0, OUT_VALID=0.
  - Each cycle SER_X = shift register bit 0, and the core computes SER_S combinationally (Mealy) from SER_X, its carry and the constant bit.
  - At posedge: shift the input right by 1, shift SER_S into the result MSB-side so the word ends LSB-aligned, update carry, counter+1.
  - Constant addend per digit is 0011 LSB-first: bits 1,1,0,0 at digit-bit positions 0..3.
  - At digit-bit 3 the carry-out goes to OUT_OVF[digit] and the carry clears to 0 for the next digit. No carry propagates between digits.
  - After bit 4*NDIG-1: go to DONE.
- DONE:
  - OUT_VALID=1 and outputs held stable until OUT_READY=1 at a posedge, then go to IDLE.
  - IN_READY=0 throughout DONE; no overlap of input and output transfers.
- Latency: accept at posedge t; OUT_VALID asserted in the cycle following posedge t+4*NDIG. Minimum spacing between accepted words is 4*NDIG+2 cycles.
- Invalid BCD (10..15): converted arithmetically with no error. 13..15 set OUT_OVF for that digit.
- OUT_V = |OUT_OVF, valid only while OUT_VALID=1.
- IN_VALID outside IDLE is ignored. The producer must hold IN_DATA until IN_READY.

Decomposition:
- Shared package plus3_pkg:
  - state encoding (IDLE=0, SHIFT=1, DONE=2, 2 bits);
  - constant EX3_ADDEND=4'b0011;
  - constant DIGIT_BITS=4.
- One sub-module: plus3_serial_core.
  - Ports: CLK, RST_N, CLR (carry clear), X, K (addend bit), S, CO.
  - One carry flip-flop; S and CO combinational.
  - The controller drives K from EX3_ADDEND indexed by the digit-bit counter.

Test Plan:
- NDIG=1, IN_DATA=4'h5 -> after 4 SHIFT cycles OUT_DATA=4'h8, OUT_OVF=0, OUT_V=0. SER_X sequence 1,0,1,0; SER_S sequence 0,0,0,1.
- NDIG=2, IN_DATA=8'h47 -> OUT_DATA=8'h7A, OUT_OVF=2'b00; OUT_VALID asserted in the cycle after posedge t+8.
- NDIG=2, IN_DATA=8'hD9 -> OUT_DATA=8'h0C, OUT_OVF=2'b10, OUT_V=1. Digit 0's carry must not leak into digit 1.
- Backpressure: OUT_READY=0 for 5 cycles in DONE -> OUT_VALID, OUT_DATA and OUT_OVF stable, IN_READY=0. One cycle after OUT_READY=1, IN_READY=1.
- Reset mid-SHIFT: RST_N=0 at SHIFT bit 3 -> next cycle IN_READY=1, OUT_VALID=0. A following word 8'h12 yields 8'h45 with no corruption from the aborted word.
- Back-to-back words with IN_VALID held high -> each accepted exactly once; IN_VALID during SHIFT/DONE ignored; results 8'h00->8'h33, then 8'h99->8'hCC.

Source files
------------

// File: rtl/plus3_pkg.sv
// Shared types and constants for the bit-serial excess-3 converter.
package plus3_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DIGIT_BITS = 4;
   localparam logic [DIGIT_BITS-1:0] EX3_ADDEND = 4'b0011;
endpackage

// File: rtl/plus3_serial_ctrl_if.sv
// Parallel in/out handshakes plus serial debug taps of the controller.
interface plus3_serial_ctrl_if #(
   parameter int NDIG = 2
);
   logic [4*NDIG-1:0] IN_DATA;
   logic              IN_VALID;
   logic              IN_READY;
   logic [4*NDIG-1:0] OUT_DATA;
   logic [NDIG-1:0]   OUT_OVF;
   logic              OUT_V;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic              SER_X;
   logic              SER_S;

   modport master (
      output IN_DATA, IN_VALID, OUT_READY,
      input  IN_READY, OUT_DATA, OUT_OVF, OUT_V,
      input  OUT_VALID, SER_X, SER_S
   );

   modport slave (
      input  IN_DATA, IN_VALID, OUT_READY,
      output IN_READY, OUT_DATA, OUT_OVF, OUT_V,
      output OUT_VALID, SER_X, SER_S
   );
endinterface

// File: rtl/plus3_serial_core.sv
// One-bit serial adder: combinational sum/carry-out, registered carry.
module plus3_serial_core (
   input  logic CLK,
   input  logic RST_N,
   input  logic CLR,
   input  logic X,
   input  logic K,
   output logic S,
   output logic CO
);
   logic carry;

   assign S  = X ^ K ^ carry;
   assign CO = (X & K) | (X & carry) | (K & carry);

   always_ff @(posedge CLK) begin
      if (!RST_N || CLR) begin
         carry <= 1'b0;
      end else begin
         carry <= CO;
      end
   end
endmodule

// File: rtl/plus3_serial_ctrl.sv
// Streams a BCD word LSB-first through the serial core and
// reassembles the excess-3 result with per-digit overflow.
module plus3_serial_ctrl #(
   parameter int NDIG = 2
) (
   input logic CLK,
   input logic RST_N,
   plus3_serial_ctrl_if.slave bus
);
   import plus3_pkg::*;

   localparam int W  = DIGIT_BITS * NDIG;
   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    sreg;
   logic [W-1:0]    rreg;
   logic [NDIG-1:0] ovf;
   logic [NDIG-1:0] dmask;
   logic [1:0]      dbit;
   logic            x;
   logic            k;
   logic            s;
   logic            co;
   logic            clr;
   logic            accept;
   logic            shift;

   assign dbit = cnt[1:0];
   assign x    = sreg[0];
   assign k    = EX3_ADDEND[dbit];

   // Carry never crosses a digit boundary.
   assign clr = !shift || (dbit == 2'd3);

   plus3_serial_core u_core (
      .CLK   (CLK),
      .RST_N (RST_N),
      .CLR   (clr),
      .X     (x),
      .K     (k),
      .S     (s),
      .CO    (co)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      accept        = 1'b0;
      shift         = 1'b0;
      bus.IN_READY  = 1'b0;
      bus.OUT_VALID = 1'b0;
      unique case (state)
         IDLE: begin
            bus.IN_READY = 1'b1;
            if (bus.IN_VALID) begin
               accept   = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            shift = 1'b1;
            if (cnt == LAST) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            bus.OUT_VALID = 1'b1;
            if (bus.OUT_READY) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // One-hot select of the digit whose last bit is in flight.
   always_comb begin
      dmask    = '0;
      dmask[0] = 1'b1;
      dmask    = dmask << (cnt >> 2);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt  <= '0;
         sreg <= '0;
         rreg <= '0;
         ovf  <= '0;
      end else if (accept) begin
         cnt  <= '0;
         sreg <= bus.IN_DATA;
         rreg <= '0;
         ovf  <= '0;
      end else if (shift) begin
         cnt  <= cnt + CW'(1);
         sreg <= sreg >> 1;
         rreg <= {s, rreg[W-1:1]};
         if (dbit == 2'd3) begin
            ovf <= (ovf & ~dmask) | (dmask & {NDIG{co}});
         end
      end
   end

   assign bus.OUT_DATA = rreg;
   assign bus.OUT_OVF  = ovf;
   assign bus.OUT_V    = |ovf;
   assign bus.SER_X    = x;
   assign bus.SER_S    = s;
endmodule
